data_arrays_0_ctrl: RTL

- Access controller directly upstream of the data_arrays_0 SRAM wrapper in the L1 data cache.
- Arbitrates CPU requests (read, or byte-masked write) against line-refill beat writes.
- Drives the single-port RW0 interface and returns read data through a ready/valid response channel.
- Absorbs the 1-cycle SRAM read latency with a small response queue and credit counter, so no read data is ever lost under response backpressure.

---
 rtl/data_arrays_0_pkg.sv | 34 +++
 rtl/data_arrays_0_ctrl_if.sv | 38 +++
 rtl/data_arrays_0_resp_q.sv | 65 ++++++
 rtl/data_arrays_0_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/data_arrays_0_pkg.sv
// Shared widths, request struct and small helpers for the data_arrays_0
// access controller and its response queue.
package data_arrays_0_pkg;

  localparam int ADDR_W         = 10;
  localparam int DATA_BYTES     = 16;
  localparam int DATA_W         = 8 * DATA_BYTES;
  localparam int MASK_W         = DATA_BYTES;
  localparam int RESP_DEPTH_DEF = 2;

  localparam logic [MASK_W-1:0] FULL_MASK = 16'hFFFF;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } req_t;

  // Which requester owns the RW0 port this cycle.
  typedef enum logic [1:0] {
    SRC_IDLE   = 2'd0,
    SRC_REFILL = 2'd1,
    SRC_CPU_WR = 2'd2,
    SRC_CPU_RD = 2'd3
  } src_e;

  // A new request may only be accepted while every read already queued or
  // still inside the SRAM has a guaranteed queue slot, plus one spare.
  function automatic logic has_credit(input int queued, input int inflight, input int depth);
    return (queued + inflight) < depth;
  endfunction

endpackage

// File: rtl/data_arrays_0_ctrl_if.sv
// CPU request, refill and read-response channels of the data_arrays_0
// controller. master = cache pipeline side, slave = controller.
interface data_arrays_0_ctrl_if;
  import data_arrays_0_pkg::*;

  logic              io_req_valid;
  logic              io_req_ready;
  logic [ADDR_W-1:0] io_req_bits_addr;
  logic              io_req_bits_write;
  logic [DATA_W-1:0] io_req_bits_wdata;
  logic [MASK_W-1:0] io_req_bits_wmask;

  logic              io_refill_valid;
  logic              io_refill_ready;
  logic [ADDR_W-1:0] io_refill_addr;
  logic [DATA_W-1:0] io_refill_data;

  logic              io_resp_valid;
  logic              io_resp_ready;
  logic [DATA_W-1:0] io_resp_bits_data;

  modport master (
    output io_req_valid, io_req_bits_addr, io_req_bits_write,
           io_req_bits_wdata, io_req_bits_wmask,
           io_refill_valid, io_refill_addr, io_refill_data,
           io_resp_ready,
    input  io_req_ready, io_refill_ready, io_resp_valid, io_resp_bits_data
  );

  modport slave (
    input  io_req_valid, io_req_bits_addr, io_req_bits_write,
           io_req_bits_wdata, io_req_bits_wmask,
           io_refill_valid, io_refill_addr, io_refill_data,
           io_resp_ready,
    output io_req_ready, io_refill_ready, io_resp_valid, io_resp_bits_data
  );

endinterface

// File: rtl/data_arrays_0_resp_q.sv
// Read-response FIFO. When empty, incoming data is presented on the output
// in the same cycle and only stored if the consumer does not take it.
module data_arrays_0_resp_q
  import data_arrays_0_pkg::*;
#(
  parameter int DEPTH = RESP_DEPTH_DEF,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enq_valid,
  input  logic [DATA_W-1:0] enq_data,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [DATA_W-1:0] deq_data,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // Bypass path: an empty queue forwards the incoming beat directly.
  always_comb begin
    deq_valid = empty ? enq_valid : 1'b1;
    deq_data  = empty ? enq_data : mem[rd_ptr];
    push      = enq_valid && !(empty && deq_ready);
    pop       = !empty && deq_ready;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= enq_data;
  end

  // The upstream credit rule must keep a read from landing on a full queue.
  assert property (@(posedge clock) disable iff (reset) !(push && full));

endmodule

// File: rtl/data_arrays_0_ctrl.sv
// Access controller in front of the data_arrays_0 single-port SRAM.
// Refill beats win over CPU requests; CPU reads return one cycle later
// through a credit-protected response queue.
// Optional build macro: DATA_ARRAYS_0_CTRL_STATS_EN adds read/write/stall
// counters; without it io_stats_* are tied to zero.
module data_arrays_0_ctrl
  import data_arrays_0_pkg::*;
#(
  parameter int RESP_DEPTH = RESP_DEPTH_DEF
) (
  input  logic              clock,
  input  logic              reset,
  data_arrays_0_ctrl_if.slave bus,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [DATA_W-1:0] sram_wdata,
  output logic [MASK_W-1:0] sram_wmask,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [31:0]       io_stats_reads,
  output logic [31:0]       io_stats_writes,
  output logic [31:0]       io_stats_stalls
);

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  req_t              req;
  src_e              src;
  logic              req_ready;
  logic              refill_ready;
  logic              inflight;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  q_count;
  logic              q_valid;
  logic [DATA_W-1:0] q_data;

  assign req.addr  = bus.io_req_bits_addr;
  assign req.write = bus.io_req_bits_write;
  assign req.wdata = bus.io_req_bits_wdata;
  assign req.wmask = bus.io_req_bits_wmask;

  // Ready ignores the write bit: writes also wait when credits run out.
  assign refill_ready = !reset;
  assign req_ready    = !reset && !bus.io_refill_valid &&
                        has_credit(int'(q_count), int'(inflight), RESP_DEPTH);

  assign bus.io_refill_ready = refill_ready;
  assign bus.io_req_ready    = req_ready;

  // Pick the owner of the RW0 port for this cycle.
  always_comb begin
    src = SRC_IDLE;
    if (bus.io_refill_valid && refill_ready) begin
      src = SRC_REFILL;
    end else if (bus.io_req_valid && req_ready) begin
      src = req.write ? SRC_CPU_WR : SRC_CPU_RD;
    end
  end

  // Drive RW0; addr/wdata hold their last value when idle, all zero in reset.
  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = addr_q;
    sram_wdata = wdata_q;
    sram_wmask = '0;
    case (src)
      SRC_REFILL: begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_addr  = bus.io_refill_addr;
        sram_wdata = bus.io_refill_data;
        sram_wmask = FULL_MASK;
      end
      SRC_CPU_WR: begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_addr  = req.addr;
        sram_wdata = req.wdata;
        sram_wmask = req.wmask;
      end
      SRC_CPU_RD: begin
        sram_en   = 1'b1;
        sram_addr = req.addr;
      end
      default: ;
    endcase
    if (reset) begin
      sram_addr  = '0;
      sram_wdata = '0;
    end
  end

  // Remember the last issued address/data so idle cycles do not toggle them.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (src != SRC_IDLE) begin
      addr_q <= sram_addr;
      if (sram_wmode) wdata_q <= sram_wdata;
    end
  end

  // A read issued this cycle has its data on sram_rdata next cycle.
  always_ff @(posedge clock) begin
    if (reset) inflight <= 1'b0;
    else       inflight <= (src == SRC_CPU_RD);
  end

  data_arrays_0_resp_q #(
    .DEPTH (RESP_DEPTH),
    .CNT_W (CNT_W)
  ) u_resp_q (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (inflight),
    .enq_data  (sram_rdata),
    .deq_valid (q_valid),
    .deq_ready (bus.io_resp_ready),
    .deq_data  (q_data),
    .count     (q_count)
  );

  assign bus.io_resp_valid     = q_valid && !reset;
  assign bus.io_resp_bits_data = q_data;

`ifdef DATA_ARRAYS_0_CTRL_STATS_EN
  logic [31:0] stat_reads;
  logic [31:0] stat_writes;
  logic [31:0] stat_stalls;

  // Free-running event counters; they simply wrap at 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_reads  <= '0;
      stat_writes <= '0;
      stat_stalls <= '0;
    end else begin
      if (src == SRC_CPU_RD) stat_reads <= stat_reads + 32'd1;
      if (src == SRC_CPU_WR || src == SRC_REFILL) stat_writes <= stat_writes + 32'd1;
      if (bus.io_req_valid && !req_ready) stat_stalls <= stat_stalls + 32'd1;
    end
  end

  assign io_stats_reads  = stat_reads;
  assign io_stats_writes = stat_writes;
  assign io_stats_stalls = stat_stalls;
`else
  assign io_stats_reads  = '0;
  assign io_stats_writes = '0;
  assign io_stats_stalls = '0;
`endif

endmodule
